// File: rtl/ascon_sbox_ti_serial.sv
// Serial, registered 3-share threshold implementation of the Ascon S-box layer; SLICE_W columns per cycle.
// Define ASCON_SBOX_TI_REMASK_EN to add the rnd0/rnd1 ports that refresh every output slice.
module ascon_sbox_ti_serial #(
  parameter int LANE_W  = 64,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] x0_0,
  input  logic [LANE_W-1:0] x0_1,
  input  logic [LANE_W-1:0] x0_2,
  input  logic [LANE_W-1:0] x1_0,
  input  logic [LANE_W-1:0] x1_1,
  input  logic [LANE_W-1:0] x1_2,
  input  logic [LANE_W-1:0] x2_0,
  input  logic [LANE_W-1:0] x2_1,
  input  logic [LANE_W-1:0] x2_2,
  input  logic [LANE_W-1:0] x3_0,
  input  logic [LANE_W-1:0] x3_1,
  input  logic [LANE_W-1:0] x3_2,
  input  logic [LANE_W-1:0] x4_0,
  input  logic [LANE_W-1:0] x4_1,
  input  logic [LANE_W-1:0] x4_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] y0_0,
  output logic [LANE_W-1:0] y0_1,
  output logic [LANE_W-1:0] y0_2,
  output logic [LANE_W-1:0] y1_0,
  output logic [LANE_W-1:0] y1_1,
  output logic [LANE_W-1:0] y1_2,
  output logic [LANE_W-1:0] y2_0,
  output logic [LANE_W-1:0] y2_1,
  output logic [LANE_W-1:0] y2_2,
  output logic [LANE_W-1:0] y3_0,
  output logic [LANE_W-1:0] y3_1,
  output logic [LANE_W-1:0] y3_2,
  output logic [LANE_W-1:0] y4_0,
  output logic [LANE_W-1:0] y4_1,
  output logic [LANE_W-1:0] y4_2,
  output logic              busy
`ifdef ASCON_SBOX_TI_REMASK_EN
  ,
  input  logic [5*SLICE_W-1:0] rnd0,
  input  logic [5*SLICE_W-1:0] rnd1
`endif
);

  localparam int NSLICE = LANE_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IDX_W  = (LANE_W > 1) ? $clog2(LANE_W) : 1;
  localparam logic [IDX_W-1:0] SLW = IDX_W'(SLICE_W);

  typedef logic [4:0][SLICE_W-1:0] slice_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [2:0][4:0][LANE_W-1:0]     xs_q, xs_d;
  logic [2:0][4:0][LANE_W-1:0]     y_q, y_d;
  logic [2:0][4:0][LANE_W-1:0]     xin;
  logic [IDX_W-1:0]                idx;
  slice_t                          sl [3];
  slice_t                          fo [3];

  // Linear input layer of the S-box; applied to each share independently.
  function automatic slice_t lin_f(input slice_t x);
    slice_t a;
    a[0] = x[0] ^ x[4];
    a[1] = x[1];
    a[2] = x[2] ^ x[1];
    a[3] = x[3];
    a[4] = x[4] ^ x[3];
    return a;
  endfunction

  // Component function: u and v are the two shares this output share may see.
  function automatic slice_t ti_f(input slice_t u, input slice_t v);
    slice_t au;
    slice_t av;
    slice_t b;
    slice_t y;
    au = lin_f(u);
    av = lin_f(v);
    for (int i = 0; i < 5; i++) begin
      b[i] = au[i] ^ au[(i + 2) % 5] ^ (au[(i + 1) % 5] & au[(i + 2) % 5])
           ^ (au[(i + 1) % 5] & av[(i + 2) % 5]) ^ (av[(i + 1) % 5] & au[(i + 2) % 5]);
    end
    y[0] = b[0] ^ b[4];
    y[1] = b[0] ^ b[1];
    y[2] = b[2];
    y[3] = b[2] ^ b[3];
    y[4] = b[4];
    return y;
  endfunction

  assign xin[0] = {x4_0, x3_0, x2_0, x1_0, x0_0};
  assign xin[1] = {x4_1, x3_1, x2_1, x1_1, x0_1};
  assign xin[2] = {x4_2, x3_2, x2_2, x1_2, x0_2};
  assign idx    = IDX_W'(cnt_q) * SLW;

  // Slice extraction and share-wise evaluation; share 0 carries the lane-2 complement.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      for (int l = 0; l < 5; l++) begin
        sl[s][l] = xs_q[s][l][idx +: SLICE_W];
      end
    end
    for (int s = 0; s < 3; s++) begin
      fo[s] = ti_f(sl[(s + 1) % 3], sl[(s + 2) % 3]);
    end
    fo[0][2] = ~fo[0][2];
`ifdef ASCON_SBOX_TI_REMASK_EN
    for (int l = 0; l < 5; l++) begin
      fo[0][l] = fo[0][l] ^ rnd0[l*SLICE_W +: SLICE_W];
      fo[1][l] = fo[1][l] ^ rnd1[l*SLICE_W +: SLICE_W];
      fo[2][l] = fo[2][l] ^ rnd0[l*SLICE_W +: SLICE_W] ^ rnd1[l*SLICE_W +: SLICE_W];
    end
`endif
  end

  // Next-state logic: capture, per-slice write-back, and share scrubbing on exit from DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xs_d    = xs_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xs_d    = xin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int s = 0; s < 3; s++) begin
          for (int l = 0; l < 5; l++) begin
            y_d[s][l][idx +: SLICE_W] = fo[s][l];
          end
        end
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          xs_d    = '0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, share and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xs_q    <= xs_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);

  assign y0_0 = y_q[0][0];
  assign y1_0 = y_q[0][1];
  assign y2_0 = y_q[0][2];
  assign y3_0 = y_q[0][3];
  assign y4_0 = y_q[0][4];
  assign y0_1 = y_q[1][0];
  assign y1_1 = y_q[1][1];
  assign y2_1 = y_q[1][2];
  assign y3_1 = y_q[1][3];
  assign y4_1 = y_q[1][4];
  assign y0_2 = y_q[2][0];
  assign y1_2 = y_q[2][1];
  assign y2_2 = y_q[2][2];
  assign y3_2 = y_q[2][3];
  assign y4_2 = y_q[2][4];

endmodule

// File: tb/tb_ascon_sbox_ti_serial.sv
// Scoreboard bench for ascon_sbox_ti_serial: driver pushes expected unshared results,
// a negedge monitor pops and compares on every out_valid&&out_ready.
module tb_ascon_sbox_ti_serial;
  parameter int SLICE_W = 8;
  localparam int LANE_W = 64;
  localparam int NSLICE = LANE_W / SLICE_W;

  typedef logic [4:0][63:0] lanes_t;
  typedef struct {
    lanes_t exp;
    int     probe;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] xw [3][5];
  wire  [63:0] yw [3][5];
  wire         in_ready;
  wire         out_valid;
  wire         busy;
`ifdef ASCON_SBOX_TI_REMASK_EN
  logic [5*SLICE_W-1:0] rnd0;
  logic [5*SLICE_W-1:0] rnd1;
`endif

  sb_t         sb[$];
  int          errs = 0;
  int          checks = 0;
  int          ncyc = 0;
  int          t0 = 0;
  logic        prev_ov = 1'b0;
  lanes_t      last_y [3];
  logic [4:0]  sbox_tbl [32];

  always #5 clk = ~clk;

  ascon_sbox_ti_serial #(.LANE_W(LANE_W), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0_0(xw[0][0]), .x0_1(xw[1][0]), .x0_2(xw[2][0]),
    .x1_0(xw[0][1]), .x1_1(xw[1][1]), .x1_2(xw[2][1]),
    .x2_0(xw[0][2]), .x2_1(xw[1][2]), .x2_2(xw[2][2]),
    .x3_0(xw[0][3]), .x3_1(xw[1][3]), .x3_2(xw[2][3]),
    .x4_0(xw[0][4]), .x4_1(xw[1][4]), .x4_2(xw[2][4]),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_0(yw[0][0]), .y0_1(yw[1][0]), .y0_2(yw[2][0]),
    .y1_0(yw[0][1]), .y1_1(yw[1][1]), .y1_2(yw[2][1]),
    .y2_0(yw[0][2]), .y2_1(yw[1][2]), .y2_2(yw[2][2]),
    .y3_0(yw[0][3]), .y3_1(yw[1][3]), .y3_2(yw[2][3]),
    .y4_0(yw[0][4]), .y4_1(yw[1][4]), .y4_2(yw[2][4]),
`ifdef ASCON_SBOX_TI_REMASK_EN
    .rnd0(rnd0), .rnd1(rnd1),
`endif
    .busy(busy)
  );

`ifdef ASCON_SBOX_TI_REMASK_EN
  always @(negedge clk) begin
    for (int i = 0; i < 5*SLICE_W; i++) begin
      rnd0[i] = 1'($urandom_range(0, 1));
      rnd1[i] = 1'($urandom_range(0, 1));
    end
  end
`endif

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  function automatic lanes_t yshare(input int s);
    lanes_t r;
    for (int l = 0; l < 5; l++) r[l] = yw[s][l];
    return r;
  endfunction

  function automatic lanes_t rnd_lanes();
    lanes_t r;
    for (int l = 0; l < 5; l++) r[l] = {$urandom, $urandom};
    return r;
  endfunction

  // Reference: table lookup per column, lane 0 is the column MSB.
  function automatic lanes_t sbox_model(input lanes_t x);
    lanes_t r;
    logic [4:0] v;
    logic [4:0] o;
    for (int j = 0; j < 64; j++) begin
      v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      o = sbox_tbl[v];
      r[0][j] = o[4]; r[1][j] = o[3]; r[2][j] = o[2]; r[3][j] = o[1]; r[4][j] = o[0];
    end
    return r;
  endfunction

  task automatic set_x(input lanes_t s0, input lanes_t s1, input lanes_t s2);
    for (int l = 0; l < 5; l++) begin
      xw[0][l] = s0[l];
      xw[1][l] = s1[l];
      xw[2][l] = s2[l];
    end
  endtask

  task automatic send(input lanes_t s0, input lanes_t s1, input lanes_t s2, input lanes_t exp, input int probe);
    int n;
    sb_t e;
    @(posedge clk); #1;
    set_x(s0, s1, s2);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 400);
    if (!in_ready) begin
      checks++; errs++;
      $display("FAIL send_timeout act=busy req=in_ready");
    end else begin
      e.exp = exp;
      e.probe = probe;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    set_x(rnd_lanes(), rnd_lanes(), rnd_lanes());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errs++;
      $display("FAIL drain_timeout act=%0d pending req=0", sb.size());
    end
  endtask

  // Monitor: latency on each rising out_valid, scoreboard compare on each handshake.
  always @(negedge clk) begin
    sb_t e;
    lanes_t rec;
    ncyc++;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) t0 = ncyc;
      if (out_valid && !prev_ov) check("latency", 320'(ncyc - t0), 320'(NSLICE + 1));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_output act=out_valid req=none");
        end else begin
          e = sb.pop_front();
          rec = yshare(0) ^ yshare(1) ^ yshare(2);
          check("recombined", rec, e.exp);
          if (e.probe >= 0) check($sformatf("noncomplete_share%0d", e.probe), yshare(e.probe), last_y[e.probe]);
          for (int s = 0; s < 3; s++) last_y[s] = yshare(s);
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_t z, ones, exp, u, s1, s2, a0, a1, a2, d, snap0, snap1, snap2;
    int n;
    sbox_tbl = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    z = '0;
    ones = '1;
    set_x(z, z, z);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", 320'({in_ready, out_valid, busy}), 320'(3'b100));
    for (int s = 0; s < 3; s++) check($sformatf("reset_y_share%0d", s), yshare(s), z);
    rst_n = 1'b1;

    // Zero state: S-box(0)=0x04 -> only lane 2 set.
    exp = z; exp[2] = ones[2];
    send(z, z, z, exp, -1);
    drain();

    // All ones unshared in share 0: S-box(0x1F)=0x17 -> lane 1 clear.
    exp = ones; exp[1] = z[1];
    send(ones, z, z, exp, -1);
    drain();

    // Hand-picked column pattern: columns cycle through inputs 0..31 in lane order.
    u = z;
    for (int j = 0; j < 64; j++) begin
      n = j % 32;
      u[0][j] = n[4]; u[1][j] = n[3]; u[2][j] = n[2]; u[3][j] = n[1]; u[4][j] = n[0];
    end
    s1 = rnd_lanes(); s2 = rnd_lanes();
    send(u ^ s1 ^ s2, s1, s2, sbox_model(u), -1);
    drain();

    // Random masked states, back-to-back with out_ready high.
    for (int i = 0; i < 1000; i++) begin
      u = rnd_lanes(); s1 = rnd_lanes(); s2 = rnd_lanes();
      send(u ^ s1 ^ s2, s1, s2, sbox_model(u), -1);
    end
    drain();

`ifndef ASCON_SBOX_TI_REMASK_EN
    // Non-completeness: disturbing only share k leaves output share k untouched.
    a1 = rnd_lanes(); a2 = rnd_lanes(); u = rnd_lanes(); a0 = u ^ a1 ^ a2;
    d = rnd_lanes();
    send(a0, a1, a2, sbox_model(u), -1);
    send(a0 ^ d, a1, a2, sbox_model(u ^ d), 0);
    send(a0, a1, a2, sbox_model(u), -1);
    send(a0, a1 ^ d, a2, sbox_model(u ^ d), 1);
    send(a0, a1, a2, sbox_model(u), -1);
    send(a0, a1, a2 ^ d, sbox_model(u ^ d), 2);
    drain();
`endif

    // in_valid pulsed during RUN is ignored.
    u = rnd_lanes(); s1 = rnd_lanes(); s2 = rnd_lanes();
    send(u ^ s1 ^ s2, s1, s2, sbox_model(u), -1);
    set_x(ones, z, rnd_lanes());
    in_valid = 1'b1;
    for (int i = 0; i < NSLICE && i < 3; i++) begin
      @(negedge clk);
      check("run_flags", 320'({in_ready, busy}), 320'(2'b01));
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    drain();

    // Back-pressure: DONE holds with stable outputs.
    out_ready = 1'b0;
    u = rnd_lanes(); s1 = rnd_lanes(); s2 = rnd_lanes();
    send(u ^ s1 ^ s2, s1, s2, sbox_model(u), -1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 400);
    snap0 = yshare(0); snap1 = yshare(1); snap2 = yshare(2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_flags", 320'({out_valid, in_ready, busy}), 320'(3'b100));
      check("bp_share0", yshare(0), snap0);
      check("bp_share1", yshare(1), snap1);
      check("bp_share2", yshare(2), snap2);
    end
    out_ready = 1'b1;
    drain();

    // Reset while at slice 3 of RUN.
    u = rnd_lanes(); s1 = rnd_lanes(); s2 = rnd_lanes();
    send(u ^ s1 ^ s2, s1, s2, sbox_model(u), -1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_flags", 320'({in_ready, out_valid, busy}), 320'(3'b100));
    for (int s = 0; s < 3; s++) check($sformatf("midrun_reset_y_share%0d", s), yshare(s), z);
    #1 rst_n = 1'b1;
    u = rnd_lanes(); s1 = rnd_lanes(); s2 = rnd_lanes();
    send(u ^ s1 ^ s2, s1, s2, sbox_model(u), -1);
    drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
